// File: rtl/vc_test_checking_sink.sv
// vc_test_checking_sink
//
// Test-harness sink for a val/rdy message stream. The bench preloads the
// expected messages, then starts a run. Each accepted message is compared
// in order against the next expected entry. Completion, a saturating
// mismatch count and details of the first mismatch are reported.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ld_en/ld_addr/ld_msg  expected-message memory write (IDLE only)
//   num_msgs, start     message count for the run; begin/restart a run
//   in_val/in_rdy/in_msg  upstream val/rdy message interface
//   done                all expected messages received
//   err_count           mismatch count, saturating at 16'hFFFF
//   first_err_idx/got/exp  index, received and expected message of the
//                       first mismatch
//   overflow            sticky: in_val seen while in DONE
module vc_test_checking_sink #(
    parameter int p_msg_sz   = 8,
    parameter int p_num_msgs = 1024,
    parameter int p_addr_sz  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_en,
    input  logic [p_addr_sz-1:0] ld_addr,
    input  logic [p_msg_sz-1:0]  ld_msg,
    input  logic [p_addr_sz:0]   num_msgs,
    input  logic                 start,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [p_msg_sz-1:0]  in_msg,
    output logic                 done,
    output logic [15:0]          err_count,
    output logic [p_addr_sz-1:0] first_err_idx,
    output logic [p_msg_sz-1:0]  first_err_got,
    output logic [p_msg_sz-1:0]  first_err_exp,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Expected-message store; deliberately not cleared by reset so a
    // bench can reset mid-run and rerun with the same contents.
    logic [p_msg_sz-1:0] mem [p_num_msgs];

    logic [p_addr_sz-1:0] index;
    logic [p_addr_sz:0]   count;
    logic                 err_seen;

    logic                 xfer;
    logic                 go;
    logic                 last;
    logic                 mismatch;
    logic [p_msg_sz-1:0]  exp_msg;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Moore outputs: derived from the state register only, so in_rdy has
    // no combinational dependence on in_val or in_msg.
    assign in_rdy   = (state == RUN);
    assign done     = (state == DONE);

    assign xfer     = in_val && in_rdy;
    // start is ignored while a run is in progress
    assign go       = start && (state != RUN);
    assign exp_msg  = mem[index];
    assign mismatch = (in_msg != exp_msg);
    assign last     = ({1'b0, index} == (count - 1'b1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_msgs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = (num_msgs == '0) ? DONE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory write: only in IDLE. A write in the same cycle as start lands
    // at this edge, so the first comparison of the run already sees it.
    always_ff @(posedge clk) begin
        if (state == IDLE && ld_en) begin
            mem[ld_addr] <= ld_msg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            index         <= '0;
            count         <= '0;
            err_seen      <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (go) begin
                count         <= num_msgs;
                index         <= '0;
                err_seen      <= 1'b0;
                err_count     <= '0;
                first_err_idx <= '0;
                first_err_got <= '0;
                first_err_exp <= '0;
                overflow      <= 1'b0;
            end else begin
                if (xfer) begin
                    index <= index + 1'b1;
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (!err_seen) begin
                            err_seen      <= 1'b1;
                            first_err_idx <= index;
                            first_err_got <= in_msg;
                            first_err_exp <= exp_msg;
                        end
                    end
                end
                if (state == DONE && in_val) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
